per2axi_rsp_channel: RTL and testbench
======================================

Name: per2axi_rsp_channel

Overview:
- Response stage directly downstream of the per2axi request channel.
- Consumes AXI4 B and R responses for transactions issued by the request channel. Uses the request channel's per-ID bookkeeping pulses to turn each response into exactly one peripheral-interconnect response: a one-cycle valid, a one-hot ID, 32-bit data and an error flag.
- Handles lane selection of 64-bit read data, merging of atomic (ATOP) B/R pairs, and store-conditional result encoding.

Parameters:
- PER_ID_WIDTH, 5, width of the one-hot peripheral response ID.
- AXI_ADDR_WIDTH, 32, width of the tracked request address inputs.
- AXI_DATA_WIDTH, 64, AXI R data width. Fixed at 64; any other value is an elaboration error.
- AXI_USER_WIDTH, 6, width of the B/R user fields (ignored).
- AXI_ID_WIDTH, 3, AXI ID width. The tracking table has NB_IDS = 2**AXI_ID_WIDTH entries.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- trans_req_i  in  1  one-cycle pulse: read accepted on AR
- trans_id_i  in  AXI_ID_WIDTH  ID of that read
- trans_add_i  in  AXI_ADDR_WIDTH  address of that read (bit 2 used)
- atop_req_i  in  1  one-cycle pulse: atomic accepted on AW
- atop_id_i  in  AXI_ID_WIDTH  ID of the atomic
- atop_add_i  in  AXI_ADDR_WIDTH  address of the atomic (bit 2 used)
- sc_req_i  in  1  one-cycle pulse: locked write (store-conditional) accepted on AW
- sc_id_i  in  AXI_ID_WIDTH  ID of the store-conditional
- axi_master_b_valid_i  in  1  B valid
- axi_master_b_resp_i  in  2  B response
- axi_master_b_id_i  in  AXI_ID_WIDTH  B ID
- axi_master_b_user_i  in  AXI_USER_WIDTH  unused
- axi_master_b_ready_o  out  1  B ready
- axi_master_r_valid_i  in  1  R valid
- axi_master_r_data_i  in  AXI_DATA_WIDTH  R data
- axi_master_r_resp_i  in  2  R response
- axi_master_r_last_i  in  1  R last (always 1; len is 0)
- axi_master_r_id_i  in  AXI_ID_WIDTH  R ID
- axi_master_r_user_i  in  AXI_USER_WIDTH  unused
- axi_master_r_ready_o  out  1  R ready
- per_slave_r_valid_o  out  1  response valid, one-cycle pulse
- per_slave_r_id_o  out  PER_ID_WIDTH  one-hot requester ID
- per_slave_r_opc_o  out  1  1 = bus error
- per_slave_r_rdata_o  out  32  response data

Behaviour:
- Tracking table: per ID, the state bits hi, atop_r, atop_b and sc. All are cleared by reset.
  - trans_req_i: hi[trans_id] <= trans_add_i[2].
  - atop_req_i: hi[atop_id] <= atop_add_i[2]; atop_r and atop_b are set.
  - sc_req_i: sc[sc_id] set.
  - Request pulses for the same ID in one cycle are not permitted; the SVA assertion flags this.
- Ready: axi_master_r_ready_o is constant 1 (the peripheral side has no backpressure). axi_master_b_ready_o = !axi_master_r_valid_i, so R has strict priority and B waits.
- R handshake on ID k:
  - rdata = hi[k] ? data[63:32] : data[31:0].
  - opc = r_resp[1]; an EXOKAY from an LR counts as success (opc 0).
  - If atop_r[k] is set, clear it.
  - The response is always forwarded.
- B handshake on ID k:
  - If atop_b[k] is set: clear it and drop the response (no output). The atomic's result travels on R; B and R for an atomic may arrive in either order.
  - Else if sc[k] is set: clear it; rdata = (b_resp == 2'b01 EXOKAY) ? 0 : 1.
  - Else: rdata = 0.
  - opc = b_resp[1] in both forwarding cases.
- A request pulse and a response on the same ID in the same cycle: the response uses the old table entry, then the new request's values are written.
- Output register:
  - Latency: handshake in cycle N gives per_slave_r_valid_o = 1 in cycle N+1 only.
  - per_slave_r_id_o = 1 << k. If k >= PER_ID_WIDTH the ID is all-zero and the SVA assertion fires.
  - rdata, opc and id hold their last value when valid is 0.
  - Reset values: valid 0, id 0, opc 0, rdata 0.
- Back-to-back: R and B valid every cycle gives one R response per cycle; B is starved until R drops. Starvation is accepted by design.
- Reset asserted mid-transaction: the table and output clear immediately. Later stray responses are treated as plain reads/writes (hi = 0, no flags).

Test Plan:
- Read, trans_id=2, add=0x1C04 → R data 0xAAAA5555_12345678, resp OKAY, next cycle valid=1, id=5'b00100, rdata=0xAAAA5555, opc=0.
- Plain write, B id=1 resp OKAY → next cycle id=5'b00010, rdata=0, opc=0. B resp SLVERR → opc=1.
- Store-conditional id=3: B EXOKAY → rdata=0; repeat with B OKAY → rdata=1; the sc flag is cleared after each.
- Atomic id=0, add bit2=0: B first then R data 0x0_00000007 → exactly one response, rdata=7. Repeat with R first then B → still exactly one response.
- R and B both valid same cycle → b_ready=0, the R response is emitted; B is emitted the following cycle.
- Reset asserted with atop flags set → flags cleared; a subsequent B on that ID produces a response with rdata=0.

Source files
------------

// File: rtl/per2axi_rsp_channel.sv
// per2axi_rsp_channel
//
// Response stage that sits after the per2axi request channel. It turns AXI4
// B and R responses into single-cycle peripheral responses that carry a
// one-hot ID, 32-bit data and an error flag.
//
// The request channel sends bookkeeping pulses for every accepted read,
// atomic and store-conditional. A small per-AXI-ID table keeps the
// information needed later:
//   hi     : the read targets the upper 32-bit lane of the 64-bit R beat
//   atop_r : an atomic is still waiting for its R beat
//   atop_b : an atomic is still waiting for its B beat (that B is dropped)
//   sc     : a store-conditional is waiting for its B beat
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   trans_req_i/_id_i/_add_i        read accepted on AR (address bit 2 kept)
//   atop_req_i/_id_i/_add_i         atomic accepted on AW (address bit 2 kept)
//   sc_req_i/_id_i                  store-conditional accepted on AW
//   axi_master_b_*                  AXI B channel (user field ignored)
//   axi_master_r_*                  AXI R channel (user and last ignored)
//   per_slave_r_valid_o             one-cycle response pulse
//   per_slave_r_id_o                one-hot requester ID
//   per_slave_r_opc_o               1 = bus error
//   per_slave_r_rdata_o             response data
module per2axi_rsp_channel #(
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      trans_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  input  logic                      atop_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   atop_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] atop_add_i,
  input  logic                      sc_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   sc_id_i,

  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
  output logic                      axi_master_b_ready_o,

  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
  output logic                      axi_master_r_ready_o,

  output logic                      per_slave_r_valid_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o
);

  localparam int NB_IDS = 2 ** AXI_ID_WIDTH;

  if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
    $error("per2axi_rsp_channel: AXI_DATA_WIDTH must be 64");
  end

  // Per-ID tracking table
  logic [NB_IDS-1:0] hi_q, hi_d;
  logic [NB_IDS-1:0] atop_r_q, atop_r_d;
  logic [NB_IDS-1:0] atop_b_q, atop_b_d;
  logic [NB_IDS-1:0] sc_q, sc_d;

  // Output register
  logic                    valid_q, valid_d;
  logic [PER_ID_WIDTH-1:0] id_q, id_d;
  logic                    opc_q, opc_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    r_hs;
  logic                    b_hs;
  logic [AXI_ID_WIDTH-1:0] rsp_id;
  logic [31:0]             rsp_id_ext;
  logic [PER_ID_WIDTH-1:0] rsp_onehot;

  // The peripheral side never stalls, so R is always accepted. B is only
  // accepted in cycles without R, which gives R strict priority over B.
  assign axi_master_r_ready_o = 1'b1;
  assign axi_master_b_ready_o = ~axi_master_r_valid_i;

  assign r_hs = axi_master_r_valid_i;
  assign b_hs = axi_master_b_valid_i & ~axi_master_r_valid_i;

  assign rsp_id     = r_hs ? axi_master_r_id_i : axi_master_b_id_i;
  assign rsp_id_ext = 32'(rsp_id);

  // One-hot decode. IDs that do not fit in PER_ID_WIDTH decode to all-zero.
  for (genvar gi = 0; gi < PER_ID_WIDTH; gi++) begin : g_onehot
    assign rsp_onehot[gi] = (rsp_id_ext == gi);
  end

  always_comb begin
    hi_d     = hi_q;
    atop_r_d = atop_r_q;
    atop_b_d = atop_b_q;
    sc_d     = sc_q;
    valid_d  = 1'b0;
    id_d     = id_q;
    opc_d    = opc_q;
    rdata_d  = rdata_q;

    // Responses look at the table as it was before this cycle's requests.
    if (r_hs) begin
      valid_d  = 1'b1;
      opc_d    = axi_master_r_resp_i[1];
      rdata_d  = hi_q[axi_master_r_id_i] ? axi_master_r_data_i[63:32]
                                         : axi_master_r_data_i[31:0];
      atop_r_d[axi_master_r_id_i] = 1'b0;
    end else if (b_hs) begin
      if (atop_b_q[axi_master_b_id_i]) begin
        // The atomic's result is delivered with its R beat; swallow the B.
        atop_b_d[axi_master_b_id_i] = 1'b0;
      end else begin
        valid_d = 1'b1;
        opc_d   = axi_master_b_resp_i[1];
        if (sc_q[axi_master_b_id_i]) begin
          // Store-conditional result: 0 on EXOKAY (success), 1 otherwise.
          rdata_d = (axi_master_b_resp_i == 2'b01) ? 32'd0 : 32'd1;
          sc_d[axi_master_b_id_i] = 1'b0;
        end else begin
          rdata_d = 32'd0;
        end
      end
    end

    if (valid_d) begin
      id_d = rsp_onehot;
    end

    // New requests overwrite whatever the response cleared on the same ID.
    if (trans_req_i) begin
      hi_d[trans_id_i] = trans_add_i[2];
    end
    if (atop_req_i) begin
      hi_d[atop_id_i]     = atop_add_i[2];
      atop_r_d[atop_id_i] = 1'b1;
      atop_b_d[atop_id_i] = 1'b1;
    end
    if (sc_req_i) begin
      sc_d[sc_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q     <= '0;
      atop_r_q <= '0;
      atop_b_q <= '0;
      sc_q     <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      opc_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      hi_q     <= hi_d;
      atop_r_q <= atop_r_d;
      atop_b_q <= atop_b_d;
      sc_q     <= sc_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      opc_q    <= opc_d;
      rdata_q  <= rdata_d;
    end
  end

  assign per_slave_r_valid_o = valid_q;
  assign per_slave_r_id_o    = id_q;
  assign per_slave_r_opc_o   = opc_q;
  assign per_slave_r_rdata_o = rdata_q;

  // Only address bit 2, the upper R response bit and the IDs carry meaning.
  logic unused_bits;
  assign unused_bits = ^{axi_master_b_user_i, axi_master_r_user_i,
                         axi_master_r_last_i, axi_master_r_resp_i[0],
                         trans_add_i, atop_add_i};

`ifndef SYNTHESIS
  // Two request pulses on the same ID in one cycle are illegal.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(trans_req_i && atop_req_i && (trans_id_i == atop_id_i)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(trans_req_i && sc_req_i && (trans_id_i == sc_id_i)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(atop_req_i && sc_req_i && (atop_id_i == sc_id_i)));
  // A forwarded response must map onto a representable one-hot ID.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_d |-> (rsp_id_ext < 32'(PER_ID_WIDTH)));
`endif

endmodule

// File: tb/tb_per2axi_rsp_channel.sv
// Testbench for per2axi_rsp_channel: directed steps from the test plan
// followed by a randomized phase, all checked against a behavioural model
// of what each AXI ID is still waiting for.
module tb_per2axi_rsp_channel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trans_req = 1'b0;
  logic [2:0]  trans_id = '0;
  logic [31:0] trans_add = '0;
  logic        atop_req = 1'b0;
  logic [2:0]  atop_id = '0;
  logic [31:0] atop_add = '0;
  logic        sc_req = 1'b0;
  logic [2:0]  sc_id = '0;
  logic        b_valid = 1'b0;
  logic [1:0]  b_resp = '0;
  logic [2:0]  b_id = '0;
  logic [5:0]  b_user = '0;
  logic        b_ready;
  logic        r_valid = 1'b0;
  logic [63:0] r_data = '0;
  logic [1:0]  r_resp = '0;
  logic        r_last = 1'b1;
  logic [2:0]  r_id = '0;
  logic [5:0]  r_user = '0;
  logic        r_ready;
  logic        p_valid;
  logic [4:0]  p_id;
  logic        p_opc;
  logic [31:0] p_rdata;

  always #5 clk = ~clk;

  per2axi_rsp_channel dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .trans_req_i          (trans_req),
    .trans_id_i           (trans_id),
    .trans_add_i          (trans_add),
    .atop_req_i           (atop_req),
    .atop_id_i            (atop_id),
    .atop_add_i           (atop_add),
    .sc_req_i             (sc_req),
    .sc_id_i              (sc_id),
    .axi_master_b_valid_i (b_valid),
    .axi_master_b_resp_i  (b_resp),
    .axi_master_b_id_i    (b_id),
    .axi_master_b_user_i  (b_user),
    .axi_master_b_ready_o (b_ready),
    .axi_master_r_valid_i (r_valid),
    .axi_master_r_data_i  (r_data),
    .axi_master_r_resp_i  (r_resp),
    .axi_master_r_last_i  (r_last),
    .axi_master_r_id_i    (r_id),
    .axi_master_r_user_i  (r_user),
    .axi_master_r_ready_o (r_ready),
    .per_slave_r_valid_o  (p_valid),
    .per_slave_r_id_o     (p_id),
    .per_slave_r_opc_o    (p_opc),
    .per_slave_r_rdata_o  (p_rdata)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: what each AXI ID expects of its next response.
  bit          upper_half   [8];  // last read/atomic targeted the upper lane
  bit          atomic_b_due [8];  // an atomic's B is still to come and is silent
  bit          sc_open      [8];  // a store-conditional awaits its B
  bit          exp_valid;
  logic [4:0]  exp_id;
  logic [31:0] exp_rdata;
  bit          exp_opc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      upper_half[i]   = 1'b0;
      atomic_b_due[i] = 1'b0;
      sc_open[i]      = 1'b0;
    end
    exp_valid = 1'b0;
    exp_id    = '0;
    exp_rdata = '0;
    exp_opc   = 1'b0;
  endtask

  task automatic idle_inputs();
    trans_req = 1'b0;
    atop_req  = 1'b0;
    sc_req    = 1'b0;
    b_valid   = 1'b0;
    r_valid   = 1'b0;
  endtask

  // Evaluates the model for the inputs currently driven, clocks once and
  // compares the registered outputs. Called one time unit after a rising edge.
  task automatic tick(input string tag);
    #1;
    chk({tag, "/b_ready"}, 32'(b_ready), 32'(!r_valid));
    chk({tag, "/r_ready"}, 32'(r_ready), 32'd1);
    exp_valid = 1'b0;
    if (r_valid) begin
      exp_valid = 1'b1;
      exp_id    = 5'(32'd1 << r_id);
      exp_rdata = upper_half[r_id] ? r_data[63:32] : r_data[31:0];
      exp_opc   = r_resp[1];
    end else if (b_valid) begin
      if (atomic_b_due[b_id]) begin
        atomic_b_due[b_id] = 1'b0;
      end else begin
        exp_valid = 1'b1;
        exp_id    = 5'(32'd1 << b_id);
        exp_opc   = b_resp[1];
        exp_rdata = (sc_open[b_id] && b_resp != 2'b01) ? 32'd1 : 32'd0;
        sc_open[b_id] = 1'b0;
      end
    end
    if (trans_req) upper_half[trans_id] = trans_add[2];
    if (atop_req) begin
      upper_half[atop_id]   = atop_add[2];
      atomic_b_due[atop_id] = 1'b1;
    end
    if (sc_req) sc_open[sc_id] = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "/valid"}, 32'(p_valid), 32'(exp_valid));
    chk({tag, "/id"},    32'(p_id),    32'(exp_id));
    chk({tag, "/rdata"}, p_rdata,      exp_rdata);
    chk({tag, "/opc"},   32'(p_opc),   32'(exp_opc));
    if (exp_valid)
      $display("[%0t] %s: rsp id=%b rdata=%h opc=%0b", $time, tag, p_id, p_rdata, p_opc);
    idle_inputs();
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset/valid", 32'(p_valid), 32'd0);
    chk("reset/id",    32'(p_id),    32'd0);
    chk("reset/rdata", p_rdata,      32'd0);
    chk("reset/opc",   32'(p_opc),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read with upper-lane address, then its R beat.
    trans_req = 1'b1; trans_id = 3'd2; trans_add = 32'h1C04;
    tick("rd_req");
    r_valid = 1'b1; r_id = 3'd2; r_data = 64'hAAAA5555_12345678; r_resp = 2'b00;
    tick("rd_rsp");
    tick("rd_idle");

    // Plain writes.
    b_valid = 1'b1; b_id = 3'd1; b_resp = 2'b00;
    tick("wr_okay");
    b_valid = 1'b1; b_id = 3'd1; b_resp = 2'b10;
    tick("wr_slverr");

    // Store-conditional success, failure, then flag already consumed.
    sc_req = 1'b1; sc_id = 3'd3;
    tick("sc_req1");
    b_valid = 1'b1; b_id = 3'd3; b_resp = 2'b01;
    tick("sc_exokay");
    sc_req = 1'b1; sc_id = 3'd3;
    tick("sc_req2");
    b_valid = 1'b1; b_id = 3'd3; b_resp = 2'b00;
    tick("sc_okay");
    b_valid = 1'b1; b_id = 3'd3; b_resp = 2'b00;
    tick("sc_cleared");

    // Atomic, B before R, then R before B.
    atop_req = 1'b1; atop_id = 3'd0; atop_add = 32'h0000_1000;
    tick("atop1_req");
    b_valid = 1'b1; b_id = 3'd0; b_resp = 2'b00;
    tick("atop1_b");
    r_valid = 1'b1; r_id = 3'd0; r_data = 64'h0000_0000_0000_0007; r_resp = 2'b00;
    tick("atop1_r");
    atop_req = 1'b1; atop_id = 3'd0; atop_add = 32'h0000_2000;
    tick("atop2_req");
    r_valid = 1'b1; r_id = 3'd0; r_data = 64'h0000_0000_0000_0007; r_resp = 2'b00;
    tick("atop2_r");
    b_valid = 1'b1; b_id = 3'd0; b_resp = 2'b00;
    tick("atop2_b");

    // R and B in the same cycle: R wins, B follows.
    r_valid = 1'b1; r_id = 3'd4; r_data = 64'h1111_2222_3333_4444; r_resp = 2'b10;
    b_valid = 1'b1; b_id = 3'd1; b_resp = 2'b00;
    tick("both_r");
    b_valid = 1'b1; b_id = 3'd1; b_resp = 2'b00;
    tick("both_b");

    // Reset with atomic flags pending on ID 0.
    atop_req = 1'b1; atop_id = 3'd0; atop_add = 32'h4;
    tick("rst_atop_req");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst/valid", 32'(p_valid), 32'd0);
    chk("midrst/id",    32'(p_id),    32'd0);
    chk("midrst/rdata", p_rdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b1; b_id = 3'd0; b_resp = 2'b00;
    tick("post_rst_b");
    r_valid = 1'b1; r_id = 3'd0; r_data = 64'hDEAD_BEEF_0BAD_F00D; r_resp = 2'b00;
    tick("post_rst_r");

    // Randomized traffic; response IDs stay within the one-hot range and
    // request IDs in one cycle are always distinct.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] base;
      base      = 3'($urandom_range(4));
      trans_req = ($urandom_range(3) == 0);
      trans_id  = base;
      trans_add = $urandom;
      atop_req  = ($urandom_range(5) == 0);
      atop_id   = 3'((32'(base) + 1) % 5);
      atop_add  = $urandom;
      sc_req    = ($urandom_range(5) == 0);
      sc_id     = 3'((32'(base) + 2) % 5);
      r_valid   = ($urandom_range(2) == 0);
      r_id      = 3'($urandom_range(4));
      r_data    = {$urandom, $urandom};
      r_resp    = 2'($urandom_range(3));
      b_valid   = ($urandom_range(1) == 0);
      b_id      = 3'($urandom_range(4));
      b_resp    = 2'($urandom_range(3));
      tick($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
